// File: rtl/rot_frame_sink.sv
// ---------------------------------------------------------------------------
// rot_frame_sink
//
// Capture stage downstream of the rotation pipeline output. The incoming
// pixel stream is re-timed through two register stages (s1, s2). Each pixel
// in the stream is then written to a linear capture-buffer port, and the
// line and frame geometry is checked against W x H.
//
// Parameters
//   W, H     image width / height in pixels (both >= 2)
//   ADDR_W   capture address width, W*H <= 2**ADDR_W
//
// Optional feature
//   FRAME_SINK_CHECKSUM_EN  when defined, checksum is the modulo-2^16 sum of
//                           the R+G+B bytes of every captured pixel in the
//                           frame. When undefined, checksum is tied to zero.
//
// Ports
//   Clk_in       pixel clock, rising edge
//   Reset_n      asynchronous active-low reset
//   Start_out    first pixel of a frame
//   H_Valid_out  valid for each subsequent pixel
//   H_Jump_out   end of line, high with the last pixel of the line
//   R_Bmp_Data   pixel {R,G,B}
//   err_clr      synchronous clear of the sticky error flags
//   cap_we/cap_addr/cap_data  capture write port (addr = row*W+col)
//   frame_done   one-cycle pulse after the last pixel of a frame
//   frame_count  completed frames, wraps at 8 bits
//   busy         state is CAPTURE
//   line_err     sticky line-length violation
//   pix_err      sticky stray-pixel / restart violation
//   checksum     running frame checksum
// ---------------------------------------------------------------------------
module rot_frame_sink #(
  parameter int W      = 256,
  parameter int H      = 256,
  parameter int ADDR_W = 20
) (
  input  logic              Clk_in,
  input  logic              Reset_n,
  input  logic              Start_out,
  input  logic              H_Valid_out,
  input  logic              H_Jump_out,
  input  logic [23:0]       R_Bmp_Data,
  input  logic              err_clr,
  output logic              cap_we,
  output logic [ADDR_W-1:0] cap_addr,
  output logic [23:0]       cap_data,
  output logic              frame_done,
  output logic [7:0]        frame_count,
  output logic              busy,
  output logic              line_err,
  output logic              pix_err,
  output logic [15:0]       checksum
);

  localparam int COL_W = $clog2(W);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(W * H - 1);
  localparam logic [COL_W-1:0]  LAST_COL = COL_W'(W - 1);

  typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

  state_t            state_reg, state_next;
  logic              s1_start_reg, s1_valid_reg, s1_jump_reg;
  logic [23:0]       s1_data_reg;
  logic              s2_start_reg, s2_valid_reg, s2_jump_reg;
  logic [23:0]       s2_data_reg;
  logic [ADDR_W-1:0] idx_reg;
  logic [COL_W-1:0]  col_reg, col_next;

  logic              pix, capture, stray, restart, wr_last, col_at_end;
  logic              line_viol, pix_viol;
  logic [ADDR_W-1:0] wr_addr;
  logic [COL_W-1:0]  col_cur;

  // Two-stage input re-timing.
  always_ff @(posedge Clk_in or negedge Reset_n) begin
    if (!Reset_n) begin
      s1_start_reg <= 1'b0;
      s1_valid_reg <= 1'b0;
      s1_jump_reg  <= 1'b0;
      s1_data_reg  <= '0;
      s2_start_reg <= 1'b0;
      s2_valid_reg <= 1'b0;
      s2_jump_reg  <= 1'b0;
      s2_data_reg  <= '0;
    end else begin
      s1_start_reg <= Start_out;
      s1_valid_reg <= H_Valid_out;
      s1_jump_reg  <= H_Jump_out;
      s1_data_reg  <= R_Bmp_Data;
      s2_start_reg <= s1_start_reg;
      s2_valid_reg <= s1_valid_reg;
      s2_jump_reg  <= s1_jump_reg;
      s2_data_reg  <= s1_data_reg;
    end
  end

  always_comb begin
    pix = s2_start_reg | s2_valid_reg;
    // A start is always captured. DONE applies the IDLE rules, so only
    // CAPTURE accepts a plain valid pixel.
    capture = s2_start_reg | ((state_reg == CAPTURE) & s2_valid_reg);
    stray   = s2_valid_reg & ~s2_start_reg & (state_reg != CAPTURE);
    restart = s2_start_reg & (state_reg == CAPTURE);
    wr_addr = s2_start_reg ? '0 : idx_reg;
    col_cur = s2_start_reg ? '0 : col_reg;
    col_at_end = (col_cur == LAST_COL);
    wr_last    = capture & (wr_addr == LAST_IDX);

    // A captured pixel must carry a jump exactly when it sits in the last
    // column; a jump with no pixel is always a violation.
    line_viol = (capture & (s2_jump_reg ^ col_at_end)) | (s2_jump_reg & ~pix);
    pix_viol  = stray | restart;

    col_next = col_reg;
    if (capture) begin
      col_next = (s2_jump_reg | col_at_end) ? '0 : col_cur + COL_W'(1);
    end else if (s2_jump_reg) begin
      col_next = '0;
    end

    state_next = IDLE;
    if (capture) begin
      state_next = wr_last ? DONE : CAPTURE;
    end else if (state_reg == CAPTURE) begin
      state_next = CAPTURE;
    end
  end

  always_ff @(posedge Clk_in or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg   <= IDLE;
      idx_reg     <= '0;
      col_reg     <= '0;
      cap_we      <= 1'b0;
      cap_addr    <= '0;
      cap_data    <= '0;
      frame_done  <= 1'b0;
      frame_count <= '0;
      busy        <= 1'b0;
      line_err    <= 1'b0;
      pix_err     <= 1'b0;
    end else begin
      state_reg <= state_next;
      busy      <= (state_next == CAPTURE);
      col_reg   <= col_next;
      cap_we    <= capture;
      if (capture) begin
        cap_addr <= wr_addr;
        cap_data <= s2_data_reg;
        idx_reg  <= wr_last ? '0 : wr_addr + ADDR_W'(1);
      end
      frame_done <= (state_reg == DONE);
      if (state_reg == DONE) begin
        frame_count <= frame_count + 8'd1;
      end
      // New violation takes priority over a simultaneous clear.
      line_err <= line_viol | (line_err & ~err_clr);
      pix_err  <= pix_viol | (pix_err & ~err_clr);
    end
  end

`ifdef FRAME_SINK_CHECKSUM_EN
  logic [15:0] pix_sum;
  logic [15:0] checksum_reg;

  assign pix_sum = 16'(s2_data_reg[23:16]) + 16'(s2_data_reg[15:8]) +
                   16'(s2_data_reg[7:0]);

  // The frame's first pixel (including a restart) seeds the sum.
  always_ff @(posedge Clk_in or negedge Reset_n) begin
    if (!Reset_n) begin
      checksum_reg <= '0;
    end else if (capture) begin
      checksum_reg <= s2_start_reg ? pix_sum : checksum_reg + pix_sum;
    end
  end

  assign checksum = checksum_reg;
`else
  assign checksum = 16'h0000;
`endif

endmodule

// File: tb/tb_rot_frame_sink.sv
// ---------------------------------------------------------------------------
// tb_rot_frame_sink
//
// Directed bench for rot_frame_sink with W=4, H=4, ADDR_W=8. Expected values
// are hand-computed constants; a negedge monitor logs capture writes and
// frame_done pulses for the linear stimulus sequence to check against.
// ---------------------------------------------------------------------------
module tb_rot_frame_sink;

  localparam int W = 4;
  localparam int H = 4;
  localparam int ADDR_W = 8;

`ifdef FRAME_SINK_CHECKSUM_EN
  localparam logic [15:0] CK_CLEAN = 16'h0060;  // 16 * (1+2+3)
  localparam logic [15:0] CK_LAT   = 16'h0267;  // AB+CD+EF
`else
  localparam logic [15:0] CK_CLEAN = 16'h0000;
  localparam logic [15:0] CK_LAT   = 16'h0000;
`endif

  logic              Clk_in = 1'b0;
  logic              Reset_n;
  logic              Start_out, H_Valid_out, H_Jump_out;
  logic [23:0]       R_Bmp_Data;
  logic              err_clr;
  logic              cap_we;
  logic [ADDR_W-1:0] cap_addr;
  logic [23:0]       cap_data;
  logic              frame_done;
  logic [7:0]        frame_count;
  logic              busy, line_err, pix_err;
  logic [15:0]       checksum;

  int n_cmp = 0;
  int n_bad = 0;

  int                cyc = 0;
  int                fd_n = 0;
  int                fd_cyc = 0;
  int                last_wr_cyc = 0;
  logic [ADDR_W-1:0] wr_log[$];
  logic [23:0]       wr_dat[$];

  rot_frame_sink #(.W(W), .H(H), .ADDR_W(ADDR_W)) dut (
    .Clk_in(Clk_in), .Reset_n(Reset_n), .Start_out(Start_out),
    .H_Valid_out(H_Valid_out), .H_Jump_out(H_Jump_out),
    .R_Bmp_Data(R_Bmp_Data), .err_clr(err_clr), .cap_we(cap_we),
    .cap_addr(cap_addr), .cap_data(cap_data), .frame_done(frame_done),
    .frame_count(frame_count), .busy(busy), .line_err(line_err),
    .pix_err(pix_err), .checksum(checksum)
  );

  always #5 Clk_in = ~Clk_in;

  // Monitor samples away from the active edge.
  always @(negedge Clk_in) begin
    cyc++;
    if (cap_we === 1'b1) begin
      wr_log.push_back(cap_addr);
      wr_dat.push_back(cap_data);
      last_wr_cyc = cyc;
    end
    if (frame_done === 1'b1) begin
      fd_n++;
      fd_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic st, input logic va, input logic ju, input logic [23:0] d);
    Start_out   = st;
    H_Valid_out = va;
    H_Jump_out  = ju;
    R_Bmp_Data  = d;
    @(posedge Clk_in);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drv(1'b0, 1'b0, 1'b0, 24'h0);
  endtask

  task automatic clear_log();
    wr_log.delete();
    wr_dat.delete();
    fd_n = 0;
  endtask

  // n pixels of 24'h010203; jumps on column 3, except that row 0 jumps at
  // short_at instead when short_at >= 0.
  task automatic send_frame(input int n, input int short_at);
    for (int p = 0; p < n; p++) begin
      logic ju;
      if (short_at >= 0 && p < W) ju = (p == short_at);
      else                        ju = ((p % W) == W - 1);
      drv(p == 0, p != 0, ju, 24'h010203);
    end
  endtask

  task automatic chk_addrs(input string tag, input int first, input int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] a;
      a = (first + i < wr_log.size()) ? 32'(wr_log[first + i]) : 32'hFFFF_FFFF;
      chk(tag, a, 32'(i));
    end
  endtask

  initial begin
    Reset_n = 1'b0;
    err_clr = 1'b0;
    idle(3);

    // Reset state
    chk("rst_cap_we", 32'(cap_we), 0);
    chk("rst_cap_addr", 32'(cap_addr), 0);
    chk("rst_cap_data", 32'(cap_data), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    chk("rst_frame_count", 32'(frame_count), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_errs", {30'd0, line_err, pix_err}, 0);
    chk("rst_checksum", 32'(checksum), 0);
    Reset_n = 1'b1;
    idle(2);
    $display("step reset: outputs checked");

    // Latency: Start pixel at edge k, write visible after edge k+2
    drv(1'b1, 1'b0, 1'b0, 24'hABCDEF);
    idle(1);
    chk("lat_we_early", 32'(cap_we), 0);
    idle(1);
    chk("lat_we", 32'(cap_we), 1);
    chk("lat_addr", 32'(cap_addr), 0);
    chk("lat_data", 32'(cap_data), 32'h00ABCDEF);
    chk("lat_busy", 32'(busy), 1);
    chk("lat_checksum", 32'(checksum), 32'(CK_LAT));
    idle(1);
    chk("lat_we_drop", 32'(cap_we), 0);
    chk("lat_addr_hold", 32'(cap_addr), 0);
    $display("step latency: single start pixel");
    Reset_n = 1'b0;
    idle(1);
    Reset_n = 1'b1;
    idle(1);

    // Clean frame
    clear_log();
    send_frame(16, -1);
    idle(5);
    chk("clean_writes", wr_log.size(), 16);
    chk_addrs("clean_addr", 0, 16);
    chk("clean_last_data", (wr_dat.size() > 0) ? 32'(wr_dat[wr_dat.size() - 1]) : 32'hFFFF_FFFF,
        32'h00010203);
    chk("clean_fd_n", fd_n, 1);
    chk("clean_fd_timing", fd_cyc - last_wr_cyc, 1);
    chk("clean_count", 32'(frame_count), 1);
    chk("clean_checksum", 32'(checksum), 32'(CK_CLEAN));
    chk("clean_errs", {30'd0, line_err, pix_err}, 0);
    chk("clean_busy", 32'(busy), 0);
    $display("step clean frame: %0d writes, frame_count=%0d", wr_log.size(), frame_count);

    // Short line in row 0
    clear_log();
    send_frame(16, 2);
    idle(5);
    chk("short_line_err", 32'(line_err), 1);
    chk("short_pix_err", 32'(pix_err), 0);
    chk("short_writes", wr_log.size(), 16);
    chk_addrs("short_addr", 0, 16);
    chk("short_fd_n", fd_n, 1);
    chk("short_count", 32'(frame_count), 2);
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    chk("short_clr", 32'(line_err), 0);
    // Lone jump reaching the s2 stage in the same cycle as err_clr
    drv(1'b0, 1'b0, 1'b1, 24'h0);
    idle(1);
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    chk("viol_beats_clr", 32'(line_err), 1);
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    chk("viol_clr_again", 32'(line_err), 0);
    $display("step short line: line_err set and cleared");

    // Restart after 7 pixels
    clear_log();
    send_frame(7, -1);
    send_frame(16, -1);
    idle(5);
    chk("rs_pix_err", 32'(pix_err), 1);
    chk("rs_line_err", 32'(line_err), 0);
    chk("rs_writes", wr_log.size(), 23);
    chk_addrs("rs_addr_a", 0, 7);
    chk_addrs("rs_addr_b", 7, 16);
    chk("rs_fd_n", fd_n, 1);
    chk("rs_count", 32'(frame_count), 3);
    chk("rs_checksum", 32'(checksum), 32'(CK_CLEAN));
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    chk("rs_clr", 32'(pix_err), 0);
    $display("step restart: %0d writes, frame_count=%0d", wr_log.size(), frame_count);

    // Stray pixel in IDLE
    clear_log();
    drv(1'b0, 1'b1, 1'b0, 24'h123456);
    idle(4);
    chk("stray_writes", wr_log.size(), 0);
    chk("stray_pix_err", 32'(pix_err), 1);
    chk("stray_busy", 32'(busy), 0);
    chk("stray_fd_n", fd_n, 0);
    $display("step stray pixel: pix_err=%0d", pix_err);

    // Reset mid-frame after 5 pixels, asserted between clock edges
    send_frame(5, -1);
    Start_out = 1'b0;
    H_Valid_out = 1'b0;
    H_Jump_out = 1'b0;
    R_Bmp_Data = 24'h0;
    #2;
    Reset_n = 1'b0;
    #1;
    chk("mid_rst_we", 32'(cap_we), 0);
    chk("mid_rst_addr", 32'(cap_addr), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_count", 32'(frame_count), 0);
    chk("mid_rst_pix_err", 32'(pix_err), 0);
    chk("mid_rst_checksum", 32'(checksum), 0);
    @(posedge Clk_in);
    #1;
    idle(1);
    Reset_n = 1'b1;
    idle(1);
    clear_log();
    send_frame(16, -1);
    idle(5);
    chk("post_rst_writes", wr_log.size(), 16);
    chk("post_rst_fd_n", fd_n, 1);
    chk("post_rst_count", 32'(frame_count), 1);
    chk("post_rst_errs", {30'd0, line_err, pix_err}, 0);
    $display("step reset mid-frame: frame_count=%0d after clean frame", frame_count);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rot_frame_sink.md
# rot_frame_sink

- Synthesizable capture stage directly downstream of the output interface of the rotation pipeline.
- Consumes the final rotated pixel stream (frame-start, pixel-valid, end-of-line, 24-bit RGB) and re-times it through a two-stage input pipeline.
- Writes each pixel to a linear capture-buffer port and checks frame and line geometry against W×H.
- Pulses a frame-done strobe with a frame counter and checksum. Replaces the behavioural collector loop for on-chip and regression use.

## Interface
- W, 256, image width in pixels (≥2)
- H, 256, image height in lines (≥2)
- ADDR_W, 20, capture address width; W*H ≤ 2^ADDR_W
- Clk_in  in  1  pixel clock, all logic on rising edge
- Reset_n  in  1  reset; one clock; reset is asynchronous and active-low
- Start_out  in  1  frame start; high in the cycle carrying the first pixel of a frame (H_Valid_out don't-care that cycle)
- H_Valid_out  in  1  pixel valid for every subsequent pixel
- H_Jump_out  in  1  end-of-line; high in the same cycle as the last valid pixel of a line
- R_Bmp_Data  in  24  pixel {R,G,B}
- err_clr  in  1  synchronous clear of sticky error flags
- cap_we  out  1  capture write strobe
- cap_addr  out  ADDR_W  linear pixel index, row*W+col
- cap_data  out  24  pixel written
- frame_done  out  1  one-cycle pulse after last pixel of a complete frame
- frame_count  out  8  completed frames, wraps 255→0
- busy  out  1  high while state is CAPTURE
- line_err  out  1  sticky line-length violation
- pix_err  out  1  sticky stray-pixel / restart violation
- checksum  out  16  running frame checksum (see Configuration)

## Operation
- Input pipeline: Start_out, H_Valid_out, H_Jump_out, R_Bmp_Data registered twice (s1, s2), all cleared to 0 on reset. Logic below acts on s2 signals.
- pix = s2_start | s2_valid.
- FSM states: IDLE, CAPTURE, DONE.
  - IDLE: s2_start → write pixel at addr 0, col=1, idx=1, go CAPTURE.
  - IDLE: s2_valid without s2_start → pixel dropped, pix_err set.
  - CAPTURE: pix → write at idx, idx+1, col+1. Write of idx W*H-1 → DONE.
  - CAPTURE: s2_start → pix_err set; restart at addr 0 (idx=1, col=1, checksum restarted); stay CAPTURE.
  - DONE: frame_done=1 for one cycle, frame_count+1, → IDLE. A pixel arriving in DONE takes the IDLE rules.
- Line check: on a captured pixel with s2_jump, col must equal W-1 before increment, else line_err. col resets to 0 after any jump.
  - A pixel at col=W-1 without s2_jump sets line_err; col wraps to 0.
  - s2_jump without pix sets line_err; col resets.
- idx is the sole address source; line errors never alter addressing.
- err_clr clears line_err/pix_err. If err_clr and a new violation occur in the same cycle, the violation wins (flag set).

## Timing
- Reset values: all outputs 0; state IDLE; idx, col, pipeline 0.
- Latency: pixel on inputs at edge k → s1 at k, s2 at k+1, cap_we/cap_addr/cap_data registered at k+2. The write is visible during the cycle after edge k+2.
- frame_done registered one edge after the final cap_we. frame_count and checksum hold final values from that frame_done cycle until the next frame start.
- Back-to-back frames: a Start whose s2 cycle coincides with DONE is accepted (IDLE rules); frame_done still pulses.
- cap_we low in every cycle with no written pixel; cap_addr/cap_data hold last value.
- Reset assertion mid-frame aborts immediately: no frame_done, counters zero.

## Configuration
- FRAME_SINK_CHECKSUM_EN defined: checksum = modulo-2^16 sum of R+G+B bytes of every captured pixel, zeroed on the frame's first pixel (first pixel's bytes included).
- Not defined: checksum tied to 16'h0000; adder logic absent.

## Test plan
All scenarios use W=4, H=4 unless noted.
- Clean frame: Start + 15 H_Valid pixels all 24'h010203, H_Jump on cols 3 → 16 cap_we at addr 0..15, frame_done once, frame_count=1, checksum=16'h0060 (macro on) / 0 (off), no errors.
- Latency: single Start pixel 24'hABCDEF at edge k → cap_we=1, cap_addr=0, cap_data=24'hABCDEF after edge k+2.
- Short line: H_Jump at col 2 of row 0 → line_err=1; addresses still 0..15 contiguous; frame_done still pulses; err_clr → line_err=0.
- Restart: Start again after 7 pixels → pix_err=1, next write at addr 0, frame_done only after 16 further pixels.
- Stray pixel in IDLE: H_Valid without Start → no cap_we, pix_err=1.
- Reset mid-frame after 5 pixels → all outputs 0 asynchronously; following clean frame gives frame_count=1.
